// File: rtl/rsa_pkg.sv
// Shared definitions for the RSA datapath stages (byte sequencer, exponentiation, modulus).
// Provides default byte counts, a byte-to-bit width helper and the dispatch state type.
package rsa_pkg;

    localparam int unsigned MsgBytesDef  = 2;
    localparam int unsigned KeyBytesDef  = 4;
    localparam int unsigned FifoDepthDef = 4;

    function automatic int unsigned bytes_to_bits(input int unsigned n_bytes);
        return 8 * n_bytes;
    endfunction

    typedef enum logic [1:0] {
        StIdle,
        StWait,
        StSerialize
    } seq_state_e;

endpackage

// File: rtl/word_fifo.sv
// Synchronous FIFO for whole words.
// Ports:
//   clk_i, rst_ni  clock, asynchronous active-low reset
//   push_i/data_i  write request and data (dropped when full unless a pop frees a slot)
//   pop_i          read request (ignored when empty)
//   head_o         oldest entry, valid while !empty_o
//   count_o        occupancy, 0..DEPTH
//   full_o/empty_o occupancy flags
module word_fifo #(
    parameter int unsigned WIDTH = 16,
    parameter int unsigned DEPTH = 4
) (
    input  logic                     clk_i,
    input  logic                     rst_ni,
    input  logic                     push_i,
    input  logic [WIDTH-1:0]         data_i,
    input  logic                     pop_i,
    output logic [WIDTH-1:0]         head_o,
    output logic [$clog2(DEPTH):0]   count_o,
    output logic                     full_o,
    output logic                     empty_o
);

    localparam int unsigned AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;
    localparam int unsigned CW = $clog2(DEPTH) + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW-1:0]    wr_ptr_q, rd_ptr_q;
    logic [CW-1:0]    count_q;
    logic             do_push, do_pop;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign do_pop  = pop_i && !empty_o;
    assign do_push = push_i && (!full_o || do_pop);
    assign head_o  = mem_q[rd_ptr_q];
    assign count_o = count_q;

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem_q[i] <= '0;
            end
        end else begin
            if (do_push) begin
                mem_q[wr_ptr_q] <= data_i;
                wr_ptr_q        <= wr_ptr_q + AW'(1);
            end
            if (do_pop) begin
                rd_ptr_q <= rd_ptr_q + AW'(1);
            end
            if (do_push && !do_pop) begin
                count_q <= count_q + CW'(1);
            end else if (do_pop && !do_push) begin
                count_q <= count_q - CW'(1);
            end
        end
    end

endmodule

// File: rtl/rsa_byte_sequencer.sv
// Byte-stream front/back end for the modular-exponentiation stage.
// Packs bytes big-endian into message words, buffers them in a FIFO, issues each word to the
// exponentiation block with a one-cycle start pulse and serializes the result MSB-first.
// Ports:
//   clk_in, rst_n_in                 clock, asynchronous active-low reset
//   byte_in/byte_valid_in/byte_ready_out  upstream byte handshake
//   flush_in                         zero-pad and submit a partial word
//   em_ready_out/em_value_out        start pulse and operand to the exponentiation block
//   em_busy_in/em_valid_in/em_result_in   exponentiation status and result
//   byte_out/byte_valid_out/byte_ack_in   downstream byte handshake
//   words_pending_out                FIFO occupancy
module rsa_byte_sequencer
    import rsa_pkg::*;
#(
    parameter int unsigned MSG_BYTES  = MsgBytesDef,
    parameter int unsigned KEY_BYTES  = KeyBytesDef,
    parameter int unsigned FIFO_DEPTH = FifoDepthDef
) (
    input  logic                          clk_in,
    input  logic                          rst_n_in,
    input  logic [7:0]                    byte_in,
    input  logic                          byte_valid_in,
    output logic                          byte_ready_out,
    input  logic                          flush_in,
    output logic                          em_ready_out,
    output logic [8*MSG_BYTES-1:0]        em_value_out,
    input  logic                          em_busy_in,
    input  logic                          em_valid_in,
    input  logic [8*KEY_BYTES-1:0]        em_result_in,
    output logic [7:0]                    byte_out,
    output logic                          byte_valid_out,
    input  logic                          byte_ack_in,
    output logic [$clog2(FIFO_DEPTH):0]   words_pending_out
);

    localparam int unsigned MSG_WIDTH = bytes_to_bits(MSG_BYTES);
    localparam int unsigned KEY_WIDTH = bytes_to_bits(KEY_BYTES);
    localparam int unsigned CNT_W     = (MSG_BYTES > 1) ? $clog2(MSG_BYTES) : 1;
    localparam int unsigned IDX_W     = (KEY_BYTES > 1) ? $clog2(KEY_BYTES) : 1;
    localparam int unsigned OCC_W     = $clog2(FIFO_DEPTH) + 1;

    // ---------------- packer ----------------
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [MSG_WIDTH-1:0] pack_q, pack_d;
    logic [MSG_WIDTH-1:0] cur_word;
    logic                 byte_accept, last_byte, flush_push, fifo_push;
    int unsigned          byte_pos;

    // FIFO side
    logic                 fifo_pop, fifo_full, fifo_empty;
    logic [MSG_WIDTH-1:0] fifo_head;
    logic [OCC_W-1:0]     fifo_count;

    assign byte_ready_out    = (fifo_count < OCC_W'(FIFO_DEPTH));
    assign byte_accept       = byte_valid_in && byte_ready_out;
    assign words_pending_out = fifo_count;

    always_comb begin
        byte_pos = (MSG_BYTES - 1 - int'(cnt_q)) * 8;
        cur_word = pack_q;
        if (byte_accept) begin
            cur_word[byte_pos +: 8] = byte_in;
        end
        last_byte = byte_accept && (cnt_q == CNT_W'(MSG_BYTES - 1));
        // A flush whose coincident byte completes the word folds into the normal push.
        flush_push = flush_in && !fifo_full && !last_byte && ((cnt_q != '0) || byte_accept);
        fifo_push  = last_byte || flush_push;

        cnt_d  = cnt_q;
        pack_d = pack_q;
        if (fifo_push) begin
            // Clearing the staging word gives zero padding for the next flush.
            cnt_d  = '0;
            pack_d = '0;
        end else if (byte_accept) begin
            cnt_d  = cnt_q + CNT_W'(1);
            pack_d = cur_word;
        end
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            cnt_q  <= '0;
            pack_q <= '0;
        end else begin
            cnt_q  <= cnt_d;
            pack_q <= pack_d;
        end
    end

    word_fifo #(
        .WIDTH (MSG_WIDTH),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .clk_i   (clk_in),
        .rst_ni  (rst_n_in),
        .push_i  (fifo_push),
        .data_i  (cur_word),
        .pop_i   (fifo_pop),
        .head_o  (fifo_head),
        .count_o (fifo_count),
        .full_o  (fifo_full),
        .empty_o (fifo_empty)
    );

    // ---------------- dispatch / serializer ----------------
    seq_state_e           state_q;
    logic                 em_ready_q;
    logic [MSG_WIDTH-1:0] em_value_q;
    logic [KEY_WIDTH-1:0] shift_q;
    logic [KEY_WIDTH-1:0] shift_next;
    logic [IDX_W-1:0]     idx_q;
    logic [7:0]           byte_out_q;
    logic                 byte_valid_q;

    assign fifo_pop   = (state_q == StIdle) && !fifo_empty && !em_busy_in;
    assign shift_next = shift_q << 8;

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            state_q      <= StIdle;
            em_ready_q   <= 1'b0;
            em_value_q   <= '0;
            shift_q      <= '0;
            idx_q        <= '0;
            byte_out_q   <= '0;
            byte_valid_q <= 1'b0;
        end else begin
            em_ready_q <= 1'b0;
            unique case (state_q)
                StIdle: begin
                    if (fifo_pop) begin
                        em_value_q <= fifo_head;
                        em_ready_q <= 1'b1;
                        state_q    <= StWait;
                    end
                end
                StWait: begin
                    if (em_valid_in) begin
                        shift_q      <= em_result_in;
                        byte_out_q   <= em_result_in[KEY_WIDTH-1 -: 8];
                        byte_valid_q <= 1'b1;
                        idx_q        <= '0;
                        state_q      <= StSerialize;
                    end
                end
                StSerialize: begin
                    if (byte_ack_in) begin
                        shift_q    <= shift_next;
                        byte_out_q <= shift_next[KEY_WIDTH-1 -: 8];
                        if (idx_q == IDX_W'(KEY_BYTES - 1)) begin
                            byte_valid_q <= 1'b0;
                            idx_q        <= '0;
                            state_q      <= StIdle;
                        end else begin
                            idx_q <= idx_q + IDX_W'(1);
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign em_ready_out   = em_ready_q;
    assign em_value_out   = em_value_q;
    assign byte_out       = byte_out_q;
    assign byte_valid_out = byte_valid_q;

endmodule

// File: tb/tb_rsa_byte_sequencer.sv
// Directed bench for rsa_byte_sequencer with default parameters (2-byte words, 4-byte results,
// 4-deep FIFO). Inputs are driven and outputs sampled 1 ns after each rising edge.
module tb_rsa_byte_sequencer;

    logic        clk_in = 1'b0;
    logic        rst_n_in;
    logic [7:0]  byte_in;
    logic        byte_valid_in;
    logic        byte_ready_out;
    logic        flush_in;
    logic        em_ready_out;
    logic [15:0] em_value_out;
    logic        em_busy_in;
    logic        em_valid_in;
    logic [31:0] em_result_in;
    logic [7:0]  byte_out;
    logic        byte_valid_out;
    logic        byte_ack_in;
    logic [2:0]  words_pending_out;

    int n_vec = 0;
    int n_err = 0;

    always #5 clk_in = ~clk_in;

    rsa_byte_sequencer dut (
        .clk_in            (clk_in),
        .rst_n_in          (rst_n_in),
        .byte_in           (byte_in),
        .byte_valid_in     (byte_valid_in),
        .byte_ready_out    (byte_ready_out),
        .flush_in          (flush_in),
        .em_ready_out      (em_ready_out),
        .em_value_out      (em_value_out),
        .em_busy_in        (em_busy_in),
        .em_valid_in       (em_valid_in),
        .em_result_in      (em_result_in),
        .byte_out          (byte_out),
        .byte_valid_out    (byte_valid_out),
        .byte_ack_in       (byte_ack_in),
        .words_pending_out (words_pending_out)
    );

    task automatic check_eq(input string tag, input logic [63:0] got, input logic [63:0] exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got 0x%0h expected 0x%0h (t=%0t)", tag, got, exp, $time);
        end
    endtask

    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic send_byte(input logic [7:0] b);
        byte_in       = b;
        byte_valid_in = 1'b1;
        tick();
        byte_valid_in = 1'b0;
    endtask

    // Waits (bounded) for the start pulse and checks the issued operand.
    task automatic wait_issue(input string tag, input logic [15:0] exp_val);
        int n = 0;
        while (!em_ready_out && n < 20) begin
            tick();
            n++;
        end
        check_eq({tag, "_pulse"}, 64'(em_ready_out), 64'd1);
        check_eq({tag, "_value"}, 64'(em_value_out), 64'(exp_val));
    endtask

    // Returns a result with ack held high and checks the MSB-first byte stream.
    task automatic serve(input string tag, input logic [31:0] res);
        logic [31:0] model;
        model        = res;
        byte_ack_in  = 1'b1;
        em_result_in = res;
        em_valid_in  = 1'b1;
        tick();
        em_valid_in  = 1'b0;
        for (int i = 0; i < 4; i++) begin
            check_eq({tag, "_bvalid"}, 64'(byte_valid_out), 64'd1);
            check_eq({tag, "_byte"}, 64'(byte_out), 64'(model[31:24]));
            model = model << 8;
            tick();
        end
        check_eq({tag, "_done"}, 64'(byte_valid_out), 64'd0);
        byte_ack_in = 1'b0;
    endtask

    initial begin
        int          seen;
        logic [15:0] drain_words [4];
        drain_words = '{16'h5566, 16'h7700, 16'h0102, 16'h0304};

        rst_n_in      = 1'b0;
        byte_in       = 8'h00;
        byte_valid_in = 1'b0;
        flush_in      = 1'b0;
        em_busy_in    = 1'b0;
        em_valid_in   = 1'b0;
        em_result_in  = 32'h0;
        byte_ack_in   = 1'b0;

        // Reset state
        #12;
        check_eq("rst_em_ready", 64'(em_ready_out), 64'd0);
        check_eq("rst_em_value", 64'(em_value_out), 64'd0);
        check_eq("rst_byte_out", 64'(byte_out), 64'd0);
        check_eq("rst_byte_valid", 64'(byte_valid_out), 64'd0);
        check_eq("rst_pending", 64'(words_pending_out), 64'd0);
        check_eq("rst_byte_ready", 64'(byte_ready_out), 64'd1);
        #11;
        rst_n_in = 1'b1;
        tick();

        // Result valid while idle must be ignored
        em_result_in = 32'hFFFF_FFFF;
        em_valid_in  = 1'b1;
        tick();
        em_valid_in = 1'b0;
        check_eq("idle_valid_ignored", 64'(byte_valid_out), 64'd0);

        // Basic pack and one-cycle push-to-issue latency
        send_byte(8'h12);
        check_eq("half_word_pending", 64'(words_pending_out), 64'd0);
        send_byte(8'h34);
        check_eq("push_pending", 64'(words_pending_out), 64'd1);
        check_eq("push_no_issue_yet", 64'(em_ready_out), 64'd0);
        tick();
        check_eq("issue_pulse", 64'(em_ready_out), 64'd1);
        check_eq("issue_value", 64'(em_value_out), 64'h1234);
        check_eq("issue_pending", 64'(words_pending_out), 64'd0);
        tick();
        check_eq("pulse_one_cycle", 64'(em_ready_out), 64'd0);
        check_eq("value_held", 64'(em_value_out), 64'h1234);
        serve("deadbeef", 32'hDEAD_BEEF);

        // Partial word flush
        send_byte(8'hAB);
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        wait_issue("flush", 16'hAB00);
        serve("flush_res", 32'h0102_0304);

        // Flush with empty counter is a no-op
        flush_in = 1'b1;
        tick();
        flush_in = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            if (em_ready_out) seen++;
            tick();
        end
        check_eq("empty_flush_issue", 64'(seen), 64'd0);
        check_eq("empty_flush_pending", 64'(words_pending_out), 64'd0);

        // Busy held: flush corner cases, then fill to full
        em_busy_in = 1'b1;
        send_byte(8'h55);
        byte_in       = 8'h66;
        byte_valid_in = 1'b1;
        flush_in      = 1'b1;
        tick();
        byte_valid_in = 1'b0;
        flush_in      = 1'b0;
        tick();
        check_eq("flush_on_last_single", 64'(words_pending_out), 64'd1);
        byte_in       = 8'h77;
        byte_valid_in = 1'b1;
        flush_in      = 1'b1;
        tick();
        byte_valid_in = 1'b0;
        flush_in      = 1'b0;
        check_eq("flush_with_first", 64'(words_pending_out), 64'd2);
        send_byte(8'h01);
        send_byte(8'h02);
        check_eq("busy_ready_3", 64'(byte_ready_out), 64'd1);
        send_byte(8'h03);
        send_byte(8'h04);
        check_eq("full_pending", 64'(words_pending_out), 64'd4);
        check_eq("full_ready", 64'(byte_ready_out), 64'd0);
        check_eq("busy_no_issue", 64'(em_ready_out), 64'd0);
        // Rejected byte while full
        byte_in       = 8'hEE;
        byte_valid_in = 1'b1;
        tick();
        tick();
        byte_valid_in = 1'b0;
        check_eq("reject_pending", 64'(words_pending_out), 64'd4);
        check_eq("reject_ready", 64'(byte_ready_out), 64'd0);

        // Release busy and drain in order
        em_busy_in = 1'b0;
        for (int w = 0; w < 4; w++) begin
            wait_issue("drain", drain_words[w]);
            serve("drain_res", 32'hA0B0_C0D0 + 32'(w));
        end
        check_eq("drained_pending", 64'(words_pending_out), 64'd0);

        // Sink stall during serialization
        send_byte(8'h9A);
        send_byte(8'hBC);
        wait_issue("stall", 16'h9ABC);
        byte_ack_in  = 1'b0;
        em_result_in = 32'hDEAD_BEEF;
        em_valid_in  = 1'b1;
        tick();
        em_valid_in = 1'b0;
        for (int i = 0; i < 10; i++) begin
            check_eq("stall_byte", 64'(byte_out), 64'hDE);
            check_eq("stall_valid", 64'(byte_valid_out), 64'd1);
            tick();
        end
        byte_ack_in = 1'b1;
        check_eq("resume_de", 64'(byte_out), 64'hDE);
        tick();
        check_eq("resume_ad", 64'(byte_out), 64'hAD);
        tick();
        check_eq("resume_be", 64'(byte_out), 64'hBE);
        tick();
        check_eq("resume_ef", 64'(byte_out), 64'hEF);
        tick();
        check_eq("resume_done", 64'(byte_valid_out), 64'd0);
        byte_ack_in = 1'b0;

        // Reset mid-serialization, right after 0xAD is presented
        send_byte(8'h11);
        send_byte(8'h22);
        wait_issue("abort", 16'h1122);
        byte_ack_in  = 1'b1;
        em_result_in = 32'hDEAD_BEEF;
        em_valid_in  = 1'b1;
        tick();
        em_valid_in = 1'b0;
        check_eq("abort_de", 64'(byte_out), 64'hDE);
        tick();
        check_eq("abort_ad", 64'(byte_out), 64'hAD);
        rst_n_in = 1'b0;
        #1;
        check_eq("abort_valid_clr", 64'(byte_valid_out), 64'd0);
        check_eq("abort_byte_clr", 64'(byte_out), 64'd0);
        check_eq("abort_value_clr", 64'(em_value_out), 64'd0);
        check_eq("abort_ready_set", 64'(byte_ready_out), 64'd1);
        #2;
        rst_n_in = 1'b1;
        seen = 0;
        for (int i = 0; i < 10; i++) begin
            tick();
            if (byte_valid_out || em_ready_out) seen++;
        end
        check_eq("abort_no_output", 64'(seen), 64'd0);
        byte_ack_in = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
